// File: rtl/hamming_encoder_tx.sv
// SECDED Hamming(16,11) encoder with error-injection mask, a one-entry output
// register under a valid/ready handshake, and a wrapping sent-word counter.
module hamming_encoder_tx #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      data_in,
    input  logic [15:0]      err_mask,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      code_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] words_sent
);

    localparam int DATA_W = 11;
    localparam int CODE_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Data bits occupy every non-power-of-two position in 3..15.
    function automatic logic [CODE_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        c      = '0;
        c[2]   = d[0];
        c[4]   = d[1];
        c[5]   = d[2];
        c[6]   = d[3];
        c[8]   = d[4];
        c[9]   = d[5];
        c[10]  = d[6];
        c[11]  = d[7];
        c[12]  = d[8];
        c[13]  = d[9];
        c[14]  = d[10];
        return c;
    endfunction

    // Position i lives at bit i-1; p16 must see p1..p8 already in place.
    function automatic logic [CODE_W-1:0] add_parity(input logic [CODE_W-1:0] c_in);
        logic [CODE_W-1:0] c;
        c     = c_in;
        c[0]  = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10] ^ c[12] ^ c[14];
        c[1]  = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
        c[3]  = c[4] ^ c[5] ^ c[6] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
        c[7]  = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14];
        c[15] = ^c[14:0];
        return c;
    endfunction

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        return add_parity(place_data(d));
    endfunction

    state_t            state, state_nxt;
    logic              accept;
    logic              take;
    logic [CODE_W-1:0] code_p0;
    logic [CODE_W-1:0] code_p1;
    logic [CNT_W-1:0]  sent_p1;

    // Stage p0: combinational encode; mask goes on after p16 so flips stay visible.
    always_comb begin
        code_p0 = encode(data_in) ^ err_mask;
    end

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) state_nxt = FULL;
            end
            FULL: begin
                if (out_ready && !accept) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (state)
            EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    // Stage p1: output register, loaded only on accept so it holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_p1 <= '0;
        end else if (accept) begin
            code_p1 <= code_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_p1 <= '0;
        end else if (take) begin
            sent_p1 <= sent_p1 + 1'b1;
        end
    end

    assign code_out   = code_p1;
    assign words_sent = sent_p1;

endmodule
